reg_ctx_xfer: RTL and testbench

Context save/restore engine for the register file. On request it walks all 2**pw registers, either copying them out to data memory (save) or loading them back from data memory (restore), one register per clock. It is the bulk initiator on the register file's read and write ports, sitting beside the core datapath and taking them over while busy.

---
 rtl/reg_ctx_xfer_pkg.sv | 15 +
 rtl/reg_ctx_xfer.sv | 97 +++++++++
 tb/tb_reg_ctx_xfer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_ctx_xfer_pkg.sv
// Shared types and constants for the register-file context save/restore engine.
package reg_ctx_xfer_pkg;

  localparam int DEF_PW = 4;
  localparam int NREGS  = 2**DEF_PW;
  localparam int DEF_AW = 8;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } state_t;

endpackage

// File: rtl/reg_ctx_xfer.sv
// Context save/restore engine: walks every register once, copying it to data memory
// (save) or loading it back from data memory (restore), one register per clock.
module reg_ctx_xfer
  import reg_ctx_xfer_pkg::*;
#(
  parameter int pw = DEF_PW,
  parameter int aw = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_save,
  input  logic          start_restore,
  input  logic [aw-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [pw:0]   rf_rd_addr,
  input  logic [7:0]    rf_rd_dat,
  input  logic [7:0]    rf_acc,
  output logic          rf_wr_en,
  output logic [pw:0]   rf_wr_addr,
  output logic [7:0]    rf_wr_dat,
  output logic [aw-1:0] dm_addr,
  output logic          dm_wr_en,
  output logic [7:0]    dm_wr_dat,
  input  logic [7:0]    dm_rd_dat
);

  state_t          r_state;
  logic [pw-1:0]   r_idx;
  logic [aw-1:0]   r_base;

  logic [aw-1:0]   w_dm_addr;
  logic            w_last;

  // Memory slot address wraps modulo 2**aw.
  assign w_dm_addr = r_base + aw'(r_idx);
  assign w_last    = (r_idx == {pw{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_base  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Save has priority when both requests arrive together.
          if (start_save || start_restore) begin
            r_state <= start_save ? SAVE : RESTORE;
            r_base  <= base_addr;
            r_idx   <= '0;
          end
        end
        SAVE, RESTORE: begin
          r_idx <= r_idx + pw'(1);
          if (w_last) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ports read as zero whenever the engine is not driving them, so the
  // integration level can select between engine and core purely on busy.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    busy       = (r_state != IDLE);
    done       = (r_state == DONE);
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_dat  = '0;
    dm_addr    = '0;
    dm_wr_en   = 1'b0;
    dm_wr_dat  = '0;
    case (r_state)
      SAVE: begin
        rf_rd_addr = {1'b0, r_idx};
        dm_addr    = w_dm_addr;
        dm_wr_en   = 1'b1;
        // The read port returns 0 for R0, so its value comes from the accumulator tap.
        dm_wr_dat  = (r_idx == '0) ? rf_acc : rf_rd_dat;
      end
      RESTORE: begin
        dm_addr    = w_dm_addr;
        rf_wr_en   = 1'b1;
        rf_wr_addr = {1'b0, r_idx};
        rf_wr_dat  = dm_rd_dat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_xfer.sv
// Directed bench for reg_ctx_xfer with behavioural register-file and data-memory models.
module tb_reg_ctx_xfer;
  import reg_ctx_xfer_pkg::*;

  localparam int PW = DEF_PW;
  localparam int AW = DEF_AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_save, start_restore;
  logic [AW-1:0] base_addr;
  logic          busy, done;
  logic [PW:0]   rf_rd_addr, rf_wr_addr;
  logic [7:0]    rf_rd_dat, rf_acc, rf_wr_dat;
  logic          rf_wr_en, dm_wr_en;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_wr_dat, dm_rd_dat;

  // Backdoor preload port into the models.
  logic          pre_rf_we, pre_dm_we;
  logic [7:0]    pre_addr, pre_dat;

  logic [7:0]    regs    [NREGS];
  logic [7:0]    mem     [2**AW];
  logic [7:0]    exp_mem [2**AW];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_ctx_xfer #(.pw(PW), .aw(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_save   (start_save),
    .start_restore(start_restore),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_dat    (rf_rd_dat),
    .rf_acc       (rf_acc),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_dat    (rf_wr_dat),
    .dm_addr      (dm_addr),
    .dm_wr_en     (dm_wr_en),
    .dm_wr_dat    (dm_wr_dat),
    .dm_rd_dat    (dm_rd_dat)
  );

  assign rf_rd_dat = (rf_rd_addr == '0) ? 8'h00 : regs[rf_rd_addr[PW-1:0]];
  assign rf_acc    = regs[0];
  assign dm_rd_dat = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en)       mem[dm_addr]              <= dm_wr_dat;
    else if (pre_dm_we) mem[pre_addr]             <= pre_dat;
    if (rf_wr_en)       regs[rf_wr_addr[PW-1:0]]  <= rf_wr_dat;
    else if (pre_rf_we) regs[pre_addr[PW-1:0]]    <= pre_dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic pre_mem(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_dm_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_dm_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic pre_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_rf_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_rf_we = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 2**AW; i++)
      if (mem[i] !== exp_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Pulse a request so it is sampled on the next rising edge (E0).
  task automatic pulse(input logic s, input logic r, input logic [7:0] b);
    @(negedge clk);
    start_save = s; start_restore = r; base_addr = b;
    @(posedge clk); #1;
    start_save = 1'b0; start_restore = 1'b0; base_addr = 8'h00;
  endtask

  // Follows one transfer; k counts cycles after E0. Optionally pulses
  // start_restore during cycle inj_k.
  task automatic run(input string tag, input logic s, input logic r, input logic [7:0] b,
                     input int inj_k, output int n_dm, output int n_rf);
    int done_k = -1;
    n_dm = 0; n_rf = 0;
    pulse(s, r, b);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_restore = (k == inj_k);
      if (done_k >= 0) begin
        check({tag, "_busy_fall"}, busy, 1'b0);
        break;
      end
      if (k == 1) check({tag, "_busy_rise"}, busy, 1'b1);
      if (dm_wr_en) n_dm++;
      if (rf_wr_en) n_rf++;
      if (done) done_k = k;
    end
    start_restore = 1'b0;
    check({tag, "_done_cycle"}, done_k, NREGS + 1);
  endtask

  initial begin
    int n_dm, n_rf;
    reset = 1'b1; start_save = 1'b0; start_restore = 1'b0; base_addr = 8'h00;
    pre_rf_we = 1'b0; pre_dm_we = 1'b0; pre_addr = 8'h00; pre_dat = 8'h00;

    for (int i = 0; i < 2**AW; i++) pre_mem(8'(i), 8'hEE);
    for (int i = 0; i < NREGS; i++) pre_reg(8'(i), 8'(8'h10 + i));

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dm_wr_en", dm_wr_en, 1'b0);
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_dm_addr", dm_addr, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Save R0..R15 = 0x10..0x1F to 0x40..0x4F.
    run("save40", 1'b1, 1'b0, 8'h40, 0, n_dm, n_rf);
    for (int i = 0; i < NREGS; i++) exp_mem[8'h40 + i] = 8'(8'h10 + i);
    check("save40_dm_writes", n_dm, NREGS);
    check("save40_rf_writes", n_rf, 0);
    check("save40_r0_slot", mem[8'h40], 8'h10);
    check("save40_r15_slot", mem[8'h4F], 8'h1F);
    cmp_mem("save40_mem_bad");

    // Restore R0..R15 from 0x80..0x8F = 0xA0..0xAF.
    for (int i = 0; i < NREGS; i++) pre_mem(8'(8'h80 + i), 8'(8'hA0 + i));
    run("rest80", 1'b0, 1'b1, 8'h80, 0, n_dm, n_rf);
    check("rest80_rf_writes", n_rf, NREGS);
    check("rest80_dm_writes", n_dm, 0);
    check("rest80_r0", rf_acc, 8'hA0);
    begin
      int bad = 0;
      for (int i = 0; i < NREGS; i++) if (regs[i] !== 8'(8'hA0 + i)) bad++;
      check("rest80_regs_bad", bad, 0);
    end
    cmp_mem("rest80_mem_bad");

    // Save at 0xF8 wraps through 0x00..0x07.
    run("saveF8", 1'b1, 1'b0, 8'hF8, 0, n_dm, n_rf);
    for (int i = 0; i < NREGS; i++) exp_mem[8'(8'hF8 + i)] = 8'(8'hA0 + i);
    check("saveF8_slot_FF", mem[8'hFF], 8'hA7);
    check("saveF8_slot_00", mem[8'h00], 8'hA8);
    cmp_mem("saveF8_mem_bad");

    // Both starts together: save wins.
    run("both60", 1'b1, 1'b1, 8'h60, 0, n_dm, n_rf);
    for (int i = 0; i < NREGS; i++) exp_mem[8'h60 + i] = 8'(8'hA0 + i);
    check("both60_rf_writes", n_rf, 0);
    check("both60_dm_writes", n_dm, NREGS);
    cmp_mem("both60_mem_bad");

    // Restore request mid-save is ignored.
    run("inj90", 1'b1, 1'b0, 8'h90, 6, n_dm, n_rf);
    for (int i = 0; i < NREGS; i++) exp_mem[8'h90 + i] = 8'(8'hA0 + i);
    check("inj90_rf_writes", n_rf, 0);
    check("inj90_dm_writes", n_dm, NREGS);
    cmp_mem("inj90_mem_bad");
    @(negedge clk);
    check("inj90_not_queued", busy, 1'b0);

    // Reset during transfer cycle 5: slots 0x20..0x23 written, nothing else.
    pulse(1'b1, 1'b0, 8'h20);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    @(negedge clk);
    check("rst5_mid_addr", dm_addr, 8'h24);
    reset = 1'b1;
    #1;
    check("rst5_busy", busy, 1'b0);
    check("rst5_dm_wr_en", dm_wr_en, 1'b0);
    check("rst5_dm_addr", dm_addr, 8'h00);
    check("rst5_dm_wr_dat", dm_wr_dat, 8'h00);
    check("rst5_rf_rd_addr", rf_rd_addr, 5'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst5_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) exp_mem[8'h20 + i] = 8'(8'hA0 + i);
    cmp_mem("rst5_mem_bad");

    // A following save runs normally.
    run("after_rst", 1'b1, 1'b0, 8'h20, 0, n_dm, n_rf);
    for (int i = 0; i < NREGS; i++) exp_mem[8'h20 + i] = 8'(8'hA0 + i);
    check("after_rst_dm_writes", n_dm, NREGS);
    cmp_mem("after_rst_mem_bad");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
